// File: rtl/fpu_add_sub_aligner_pkg.sv
// Shared types and defaults for the FPU add/sub alignment front end.
// The state encoding and the shift clamp rule are kept here so the top and the bench agree.
package fpu_add_sub_aligner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_EXP_W      = 8;
    localparam int DEF_MAN_W      = 23;
    localparam int DEF_SHIFT_STEP = 4;

    // Shifting past {significand, R, S} only feeds sticky, so the distance saturates here.
    function automatic int shift_clamp(input int man_w);
        return man_w + 3;
    endfunction

endpackage

// File: rtl/fpu_sticky_shifter.sv
// Combinational right shift of {significand, R, S} by k.
// Every bit pushed out below the S position is OR'ed into S.
module fpu_sticky_shifter #(
    parameter int W   = 26,
    parameter int K_W = 5
) (
    input  logic [W-1:0]   i_ext,
    input  logic [K_W-1:0] i_k,
    output logic [W-1:0]   o_ext
);

    logic [W-1:0] w_mask;
    logic [W-1:0] w_shifted;
    logic         w_lost;

    // w_mask covers bits [k-1:0], which includes the old sticky bit, so sticky never clears.
    assign w_mask    = ~({W{1'b1}} << i_k);
    assign w_lost    = |(i_ext & w_mask);
    assign w_shifted = i_ext >> i_k;
    assign o_ext     = {w_shifted[W-1:1], w_shifted[0] | w_lost};

endmodule

// File: rtl/fpu_add_sub_aligner.sv
// Orders two IEEE operands by magnitude and aligns the smaller significand over several cycles.
// The output (significands, round/sticky, sign, exponent) is consumed by the add/sub rounder.
module fpu_add_sub_aligner
    import fpu_add_sub_aligner_pkg::*;
#(
    parameter int EXP_W      = DEF_EXP_W,
    parameter int MAN_W      = DEF_MAN_W,
    parameter int SHIFT_STEP = DEF_SHIFT_STEP
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   op_a_i,
    input  logic [EXP_W+MAN_W:0]   op_b_i,
    input  logic                   sub_i,
    input  logic [2:0]             rm_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [MAN_W:0]         big_man_o,
    output logic [MAN_W:0]         small_man_o,
    output logic [1:0]             grs_o,
    output logic [EXP_W-1:0]       exp_o,
    output logic                   sign_o,
    output logic                   sign_less_o,
    output logic                   second_operand_zero_o,
    output logic                   special_o,
    output logic [2:0]             rm_o
);

    localparam int OP_W  = EXP_W + MAN_W + 1;
    localparam int EXT_W = MAN_W + 3;
    localparam int CLAMP = shift_clamp(MAN_W);
    localparam int REM_W = $clog2(CLAMP + 1);

    state_e r_state;
    state_e w_next;

    logic [MAN_W:0]     r_big_man;
    logic [EXT_W-1:0]   r_ext;
    logic [REM_W-1:0]   r_rem;
    logic [EXP_W-1:0]   r_exp;
    logic               r_sign;
    logic               r_sign_less;
    logic               r_special;
    logic [2:0]         r_rm;

    logic               w_sa, w_sb;
    logic [EXP_W-1:0]   w_ea, w_eb, w_eff_a, w_eff_b;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic [MAN_W:0]     w_sig_a, w_sig_b;
    logic               w_a_big;
    logic [EXP_W-1:0]   w_exp_big, w_exp_small, w_diff;
    logic [REM_W-1:0]   w_d;
    logic               w_special;
    logic               w_accept;
    logic [REM_W-1:0]   w_k;
    logic [EXT_W-1:0]   w_ext_shifted;

    assign w_sa = op_a_i[OP_W-1];
    assign w_sb = op_b_i[OP_W-1];
    assign w_ea = op_a_i[OP_W-2 -: EXP_W];
    assign w_eb = op_b_i[OP_W-2 -: EXP_W];
    assign w_ma = op_a_i[MAN_W-1:0];
    assign w_mb = op_b_i[MAN_W-1:0];

    // Denormals share the exponent of the smallest normal; only the hidden bit differs.
    assign w_eff_a = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eff_b = (w_eb == '0) ? EXP_W'(1) : w_eb;
    assign w_sig_a = {|w_ea, w_ma};
    assign w_sig_b = {|w_eb, w_mb};

    assign w_a_big     = {w_eff_a, w_ma} >= {w_eff_b, w_mb};
    assign w_exp_big   = w_a_big ? w_eff_a : w_eff_b;
    assign w_exp_small = w_a_big ? w_eff_b : w_eff_a;
    assign w_diff      = w_exp_big - w_exp_small;
    assign w_d         = (w_diff > EXP_W'(CLAMP)) ? REM_W'(CLAMP) : REM_W'(w_diff);
    assign w_special   = (&w_ea) | (&w_eb);

    assign w_accept = in_valid_i && (r_state == ST_IDLE) && !flush_i;
    assign w_k      = (r_rem > REM_W'(SHIFT_STEP)) ? REM_W'(SHIFT_STEP) : r_rem;

    fpu_sticky_shifter #(
        .W   (EXT_W),
        .K_W (REM_W)
    ) u_shifter (
        .i_ext (r_ext),
        .i_k   (w_k),
        .o_ext (w_ext_shifted)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (in_valid_i) w_next = (w_special || w_d == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (r_rem == w_k) w_next = ST_DONE;
            ST_DONE:  if (out_ready_i) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (flush_i) w_next = ST_IDLE;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_big_man   <= '0;
            r_ext       <= '0;
            r_rem       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_sign_less <= 1'b0;
            r_special   <= 1'b0;
            r_rm        <= '0;
        end else if (w_accept) begin
            r_big_man   <= w_a_big ? w_sig_a : w_sig_b;
            r_ext       <= {(w_a_big ? w_sig_b : w_sig_a), 2'b00};
            r_rem       <= w_special ? '0 : w_d;
            r_exp       <= w_exp_big;
            r_sign      <= w_a_big ? w_sa : (w_sb ^ sub_i);
            r_sign_less <= w_sa ^ w_sb ^ sub_i;
            r_special   <= w_special;
            r_rm        <= rm_i;
        end else if (r_state == ST_SHIFT && !flush_i) begin
            r_ext <= w_ext_shifted;
            r_rem <= r_rem - w_k;
        end
    end

    assign in_ready_o            = (r_state == ST_IDLE);
    assign out_valid_o           = (r_state == ST_DONE);
    assign big_man_o             = r_big_man;
    assign small_man_o           = r_ext[EXT_W-1:2];
    assign grs_o                 = r_ext[1:0];
    assign exp_o                 = r_exp;
    assign sign_o                = r_sign;
    assign sign_less_o           = r_sign_less;
    assign second_operand_zero_o = (r_ext[EXT_W-1:2] == '0) && (r_ext[1:0] != 2'b00);
    assign special_o             = r_special;
    assign rm_o                  = r_rm;

endmodule

// File: tb/tb_fpu_add_sub_aligner.sv
// Directed bench for the FPU add/sub aligner in single precision with a 4-bit shift step.
// Each scenario task drives its own operands and compares against hand-computed values.
module tb_fpu_add_sub_aligner;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        sub_i = 1'b0;
    logic [2:0]  rm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [23:0] big_man_o;
    logic [23:0] small_man_o;
    logic [1:0]  grs_o;
    logic [7:0]  exp_o;
    logic        sign_o;
    logic        sign_less_o;
    logic        second_operand_zero_o;
    logic        special_o;
    logic [2:0]  rm_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    fpu_add_sub_aligner #(
        .EXP_W      (8),
        .MAN_W      (23),
        .SHIFT_STEP (4)
    ) dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .flush_i               (flush_i),
        .in_valid_i            (in_valid_i),
        .in_ready_o            (in_ready_o),
        .op_a_i                (op_a_i),
        .op_b_i                (op_b_i),
        .sub_i                 (sub_i),
        .rm_i                  (rm_i),
        .out_valid_o           (out_valid_o),
        .out_ready_i           (out_ready_i),
        .big_man_o             (big_man_o),
        .small_man_o           (small_man_o),
        .grs_o                 (grs_o),
        .exp_o                 (exp_o),
        .sign_o                (sign_o),
        .sign_less_o           (sign_less_o),
        .second_operand_zero_o (second_operand_zero_o),
        .special_o             (special_o),
        .rm_o                  (rm_o)
    );

    // Presents one operation for exactly one accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [2:0] rm);
        @(negedge clk_i);
        op_a_i = a; op_b_i = b; sub_i = s; rm_i = rm; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1; -1 means out_valid_o never rose.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [2:0] rm,
                          output int lat);
        start_op(a, b, s, rm);
        lat = 1;
        while (!out_valid_o && lat < 40) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        if (!out_valid_o) lat = -1;
    endtask

    task automatic release_op();
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        checks++; if ({big_man_o, small_man_o, grs_o, exp_o, sign_o, rm_o} !== '0) begin errors++; $display("FAIL reset_data: big=%h small=%h grs=%b exp=%h", big_man_o, small_man_o, grs_o, exp_o); end
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_equal();
        int lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 3'd2, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL equal_latency: got %0d want 1", lat); end
        checks++; if (big_man_o !== 24'h800000 || small_man_o !== 24'h800000) begin errors++; $display("FAIL equal_mans: big=%h small=%h want 800000/800000", big_man_o, small_man_o); end
        checks++; if (grs_o !== 2'b00 || sign_less_o !== 1'b0 || exp_o !== 8'h7F) begin errors++; $display("FAIL equal_misc: grs=%b sl=%b exp=%h want 00/0/7f", grs_o, sign_less_o, exp_o); end
        checks++; if (rm_o !== 3'd2 || second_operand_zero_o !== 1'b0 || special_o !== 1'b0) begin errors++; $display("FAIL equal_flags: rm=%0d soz=%b sp=%b want 2/0/0", rm_o, second_operand_zero_o, special_o); end
        release_op();
    endtask

    task automatic test_shift_one();
        int lat;
        run_op(32'h3F800000, 32'h3F000000, 1'b0, 3'd0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL shift1_latency: got %0d want 2", lat); end
        checks++; if (small_man_o !== 24'h400000 || grs_o !== 2'b00 || exp_o !== 8'h7F) begin errors++; $display("FAIL shift1_data: small=%h grs=%b exp=%h want 400000/00/7f", small_man_o, grs_o, exp_o); end
        release_op();
    endtask

    task automatic test_swap();
        int lat;
        // 1.0 + (-2.0): b is larger, so sign_o comes from b and the effective op is a subtract.
        run_op(32'h3F800000, 32'hC0000000, 1'b0, 3'd3, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL swap_latency: got %0d want 2", lat); end
        checks++; if (big_man_o !== 24'h800000 || small_man_o !== 24'h400000 || exp_o !== 8'h80) begin errors++; $display("FAIL swap_data: big=%h small=%h exp=%h want 800000/400000/80", big_man_o, small_man_o, exp_o); end
        checks++; if (sign_o !== 1'b1 || sign_less_o !== 1'b1 || rm_o !== 3'd3) begin errors++; $display("FAIL swap_sign: sign=%b sl=%b rm=%0d want 1/1/3", sign_o, sign_less_o, rm_o); end
        release_op();
    endtask

    task automatic test_round_bit();
        int lat;
        run_op(32'h4B800000, 32'h3F800000, 1'b0, 3'd0, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL d24_latency: got %0d want 7", lat); end
        checks++; if (small_man_o !== 24'h0 || grs_o !== 2'b10 || second_operand_zero_o !== 1'b1) begin errors++; $display("FAIL d24_data: small=%h grs=%b soz=%b want 0/10/1", small_man_o, grs_o, second_operand_zero_o); end
        release_op();
    endtask

    task automatic test_clamp_sub();
        int lat;
        run_op(32'h4E800000, 32'h3F800000, 1'b1, 3'd0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL clamp_latency: got %0d want 8", lat); end
        checks++; if (grs_o !== 2'b01 || small_man_o !== 24'h0 || exp_o !== 8'h9D) begin errors++; $display("FAIL clamp_data: grs=%b small=%h exp=%h want 01/0/9d", grs_o, small_man_o, exp_o); end
        checks++; if (sign_less_o !== 1'b1 || sign_o !== 1'b0) begin errors++; $display("FAIL clamp_sign: sl=%b sign=%b want 1/0", sign_less_o, sign_o); end
        release_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(32'h3F800000, 32'h3F000000, 1'b0, 3'd0, lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            checks++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || small_man_o !== 24'h400000) begin errors++; $display("FAIL hold_%0d: ov=%b ir=%b small=%h want 1/0/400000", i, out_valid_o, in_ready_o, small_man_o); end
        end
        release_op();
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL release_idle: ov=%b ir=%b want 0/1", out_valid_o, in_ready_o); end
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, lat);
        checks++; if (lat !== 1 || small_man_o !== 24'h800000) begin errors++; $display("FAIL next_op: lat=%0d small=%h want 1/800000", lat, small_man_o); end
        release_op();
    endtask

    task automatic test_reset_mid();
        start_op(32'h4B800000, 32'h3F800000, 1'b0, 3'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || big_man_o !== 24'h0) begin errors++; $display("FAIL reset_mid: ov=%b ir=%b big=%h want 0/1/0", out_valid_o, in_ready_o, big_man_o); end
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_flush();
        int seen;
        start_op(32'h4B800000, 32'h3F800000, 1'b0, 3'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_shift: ir=%b ov=%b want 1/0", in_ready_o, out_valid_o); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid: valid cycles=%0d want 0", seen); end
        // Flush coinciding with an accept drops the operation.
        @(negedge clk_i);
        op_a_i = 32'h3F800000; op_b_i = 32'h3F800000; in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_accept: ir=%b ov=%b want 1/0", in_ready_o, out_valid_o); end
    endtask

    task automatic test_special();
        int lat;
        run_op(32'h7F800000, 32'h3F800000, 1'b0, 3'd0, lat);
        checks++; if (lat !== 1 || special_o !== 1'b1) begin errors++; $display("FAIL special: lat=%0d sp=%b want 1/1", lat, special_o); end
        release_op();
    endtask

    initial begin
        test_reset();
        test_equal();
        test_shift_one();
        test_swap();
        test_round_bit();
        test_clamp_sub();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        test_special();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
